// File: rtl/pcs_sync_pkg.sv
// Shared types and constants for the 1000BASE-X PCS synchronization controller.
package pcs_sync_pkg;

    localparam int unsigned CG_W   = 10;
    localparam int unsigned SUDI_W = CG_W + 1;
    localparam int unsigned GCS_W  = 2;
    localparam int unsigned ONES_W = 4;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        COMMA_DETECT_2,
        COMMA_DETECT_3,
        ACQUIRE_SYNC_1,
        ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4A
    } state_t;

    typedef struct packed {
        logic            rx_even;
        logic [CG_W-1:0] cg;
    } sudi_t;

    localparam logic [CG_W-1:0] K28_5_NEG  = 10'b0011111010;
    localparam logic [CG_W-1:0] K28_5_POS  = 10'b1100000101;
    // D16.2 as sent when current RD is positive / negative
    localparam logic [CG_W-1:0] D16_2_RDP  = 10'b1001000101;
    localparam logic [CG_W-1:0] D16_2_RDN  = 10'b0110110101;

    function automatic logic [ONES_W-1:0] popcount(input logic [CG_W-1:0] v);
        logic [ONES_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(CG_W); i++) begin
            n = n + ONES_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic is_synced(input state_t s);
        return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4,
                         SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A};
    endfunction

endpackage

// File: rtl/pcs_sync_cg_check.sv
// Combinational code-group classifier: comma detect, validity vs. running disparity, next RD.
module cg_check
    import pcs_sync_pkg::*;
(
    input  logic [CG_W-1:0] code_group,
    input  logic            rd,
    output logic            comma,
    output logic            invalid,
    output logic            rd_next
);

    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_hi;
    logic [ONES_W-1:0] ones_lo;

    // rd = 1 means positive running disparity
    always_comb begin
        ones    = popcount(code_group);
        ones_hi = popcount({4'b0000, code_group[9:4]});
        ones_lo = popcount({6'b000000, code_group[3:0]});
        comma   = (code_group[9:3] == 7'b0011111) || (code_group[9:3] == 7'b1100000);
        invalid = (ones < 4'd4) || (ones > 4'd6)
               || (ones_hi < 4'd2) || (ones_hi > 4'd4)
               || (ones_lo < 4'd1) || (ones_lo > 4'd3)
               || ((ones == 4'd6) && rd)
               || ((ones == 4'd4) && !rd);
        rd_next = rd;
        if (!invalid) begin
            if (ones == 4'd6) begin
                rd_next = 1'b1;
            end else if (ones == 4'd4) begin
                rd_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcs_sync.sv
// 1000BASE-X receive synchronization FSM: comma alignment, even/odd labelling and sync_status.
module pcs_sync
    import pcs_sync_pkg::*;
#(
    parameter int unsigned GOOD_CGS_MAX = 3
) (
    input  logic              rx_clk,
    input  logic              mr_main_reset,
    input  logic [CG_W-1:0]   code_group,
    input  logic              signal_detect,
    output logic [SUDI_W-1:0] sudi,
    output logic              sync_status
);

    state_t             state, state_nxt;
    logic               rx_even, rx_even_nxt;
    logic               rd, rd_nxt;
    logic [GCS_W-1:0]   good_cgs, good_cgs_nxt;
    logic [GCS_W:0]     good_inc;
    logic [GCS_W-1:0]   good_sat;
    logic               good_hit;
    logic               comma, invalid, rd_chk;
    logic               cgbad, is_data;
    logic [ONES_W-1:0]  ones_raw;
    sudi_t              sudi_nxt;

    cg_check u_cg_check (
        .code_group (code_group),
        .rd         (rd),
        .comma      (comma),
        .invalid    (invalid),
        .rd_next    (rd_chk)
    );

    assign cgbad    = invalid || (comma && rx_even);
    assign is_data  = !invalid && !comma;
    assign ones_raw = popcount(code_group);
    // good_cgs counts the good group being evaluated, so GOOD_CGS_MAX goods step back a level
    assign good_inc = {1'b0, good_cgs} + (GCS_W+1)'(1);
    assign good_hit = (good_inc == (GCS_W+1)'(GOOD_CGS_MAX));
    assign good_sat = good_inc[GCS_W] ? '1 : good_inc[GCS_W-1:0];

    always_comb begin
        state_nxt    = state;
        good_cgs_nxt = '0;
        case (state)
            LOSS_OF_SYNC:     if (comma) state_nxt = COMMA_DETECT_1;
            COMMA_DETECT_1:   state_nxt = is_data ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2:   state_nxt = is_data ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3:   state_nxt = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (cgbad)      state_nxt = LOSS_OF_SYNC;
                else if (comma) state_nxt = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (cgbad)      state_nxt = LOSS_OF_SYNC;
                else if (comma) state_nxt = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1:  if (cgbad) state_nxt = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2: begin
                state_nxt    = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
                good_cgs_nxt = cgbad ? '0 : GCS_W'(1);
            end
            SYNC_ACQUIRED_3: begin
                state_nxt    = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
                good_cgs_nxt = cgbad ? '0 : GCS_W'(1);
            end
            SYNC_ACQUIRED_4: begin
                state_nxt    = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
                good_cgs_nxt = cgbad ? '0 : GCS_W'(1);
            end
            SYNC_ACQUIRED_2A: begin
                if (cgbad)         state_nxt = SYNC_ACQUIRED_3;
                else if (good_hit) state_nxt = SYNC_ACQUIRED_1;
                else               good_cgs_nxt = good_sat;
            end
            SYNC_ACQUIRED_3A: begin
                if (cgbad)         state_nxt = SYNC_ACQUIRED_4;
                else if (good_hit) state_nxt = SYNC_ACQUIRED_2;
                else               good_cgs_nxt = good_sat;
            end
            SYNC_ACQUIRED_4A: begin
                if (cgbad)         state_nxt = LOSS_OF_SYNC;
                else if (good_hit) state_nxt = SYNC_ACQUIRED_3;
                else               good_cgs_nxt = good_sat;
            end
            default:          state_nxt = LOSS_OF_SYNC;
        endcase

        if (!signal_detect) begin
            state_nxt    = LOSS_OF_SYNC;
            good_cgs_nxt = '0;
        end

        rx_even_nxt = (state_nxt inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
                    ? 1'b1 : !rx_even;

        // while unsynchronized RD tracks the raw disparity without validity checks
        rd_nxt = rd_chk;
        if (state == LOSS_OF_SYNC) begin
            rd_nxt = rd;
            if (ones_raw == 4'd6) begin
                rd_nxt = 1'b1;
            end else if (ones_raw == 4'd4) begin
                rd_nxt = 1'b0;
            end
        end

        sudi_nxt.rx_even = rx_even_nxt;
        sudi_nxt.cg      = code_group;
    end

    always_ff @(posedge rx_clk) begin
        if (mr_main_reset) begin
            state       <= LOSS_OF_SYNC;
            rx_even     <= 1'b0;
            rd          <= 1'b0;
            good_cgs    <= '0;
            sudi        <= '0;
            sync_status <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_even     <= rx_even_nxt;
            rd          <= rd_nxt;
            good_cgs    <= good_cgs_nxt;
            sudi        <= sudi_nxt;
            sync_status <= is_synced(state_nxt);
        end
    end

endmodule

// File: tb/tb_pcs_sync.sv
// Scoreboard bench for pcs_sync: directed /I2/ scenarios plus randomized streams vs. a behavioural model.
module tb_pcs_sync;
    import pcs_sync_pkg::*;

    localparam int GOOD_MAX = 3;
    localparam logic [9:0] D21_5 = 10'b1010101010;

    logic        clk = 1'b0;
    logic        mr_main_reset = 1'b1;
    logic [9:0]  code_group = '0;
    logic        signal_detect = 1'b1;
    logic [10:0] sudi;
    logic        sync_status;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct packed { logic [10:0] sudi; logic sync; } exp_t;
    exp_t exp_q[$];

    // model state: phase 0=loss, 1=comma detect, 2=acquire, 3=synced
    int m_ph = 0, m_lvl = 0, m_bad = 0, m_good = 0;
    bit m_even = 0, m_rdp = 0;
    bit i2_phase = 0;

    pcs_sync #(.GOOD_CGS_MAX(GOOD_MAX)) dut (
        .rx_clk        (clk),
        .mr_main_reset (mr_main_reset),
        .code_group    (code_group),
        .signal_detect (signal_detect),
        .sudi          (sudi),
        .sync_status   (sync_status)
    );

    always #5 clk = ~clk;

    function automatic int cnt1(input logic [9:0] v, input int lo_b, input int hi_b);
        int n = 0;
        for (int i = lo_b; i <= hi_b; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_step(input logic [9:0] g, input bit sd, input bit rst);
        int ones, hi, lo;
        bit comma, inval, bad;
        exp_t e;
        if (rst) begin
            m_ph = 0; m_even = 0; m_rdp = 0; m_bad = 0; m_good = 0;
            e.sudi = '0; e.sync = 1'b0;
            exp_q.push_back(e);
            return;
        end
        ones  = cnt1(g, 0, 9);
        hi    = cnt1(g, 4, 9);
        lo    = cnt1(g, 0, 3);
        comma = (g[9:3] == 7'b0011111) || (g[9:3] == 7'b1100000);
        inval = ones < 4 || ones > 6 || hi < 2 || hi > 4 || lo < 1 || lo > 3
             || (ones == 6 && m_rdp) || (ones == 4 && !m_rdp);
        bad   = inval || (comma && m_even);
        if (m_ph == 0 || !inval) begin
            if (ones == 6) m_rdp = 1;
            else if (ones == 4) m_rdp = 0;
        end
        if (!sd) m_ph = 0;
        else case (m_ph)
            0: if (comma) begin m_ph = 1; m_lvl = 1; end
            1: begin
                if (inval || comma) m_ph = 0;
                else if (m_lvl == 3) begin m_ph = 3; m_bad = 0; m_good = 0; end
                else m_ph = 2;
            end
            2: begin
                if (bad) m_ph = 0;
                else if (comma) begin m_ph = 1; m_lvl++; end
            end
            3: begin
                if (bad) begin
                    m_good = 0;
                    if (m_bad == 3) m_ph = 0; else m_bad++;
                end else if (m_bad > 0) begin
                    m_good++;
                    if (m_good == GOOD_MAX) begin m_bad--; m_good = 0; end
                end
            end
            default: m_ph = 0;
        endcase
        m_even = (m_ph == 1) ? 1'b1 : !m_even;
        e.sudi = {m_even, g};
        e.sync = (m_ph == 3);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] g, input bit sd, input bit rst);
        @(negedge clk);
        code_group    = g;
        signal_detect = sd;
        mr_main_reset = rst;
        model_step(g, sd, rst);
        i2_phase = !i2_phase;
    endtask

    function automatic logic [9:0] i2_cg();
        if (!i2_phase) return m_rdp ? K28_5_POS : K28_5_NEG;
        return m_rdp ? D16_2_RDP : D16_2_RDN;
    endfunction

    task automatic send_i2(input int n);
        for (int i = 0; i < n; i++) send(i2_cg(), 1'b1, 1'b0);
    endtask

    task automatic chk_sync(input bit exp_v, input string name);
        @(posedge clk);
        #3;
        n_tests++;
        if (sync_status !== exp_v) begin
            n_fail++;
            $display("FAIL %s: sync_status=%0b expected %0b", name, sync_status, exp_v);
        end
    endtask

    // monitor: every edge consumes one expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (sudi !== e.sudi) begin
                    n_fail++;
                    $display("FAIL sudi @%0t: got %03h expected %03h", $time, sudi, e.sudi);
                end
                n_tests++;
                if (sync_status !== e.sync) begin
                    n_fail++;
                    $display("FAIL sync_status @%0t: got %0b expected %0b", $time, sync_status, e.sync);
                end
            end
        end
    end

    initial begin
        int r;
        logic [9:0] g;
        bit sd, rst;

        send('0, 1'b1, 1'b1);
        chk_sync(1'b0, "reset");
        i2_phase = 0;

        // acquisition from cycle 0
        send_i2(5);
        chk_sync(1'b0, "acq_5th_group");
        send_i2(1);
        chk_sync(1'b1, "acq_6th_group");
        send_i2(4);

        // isolated errors, each followed by 4 data groups
        for (int k = 0; k < 3; k++) begin
            send(10'h000, 1'b1, 1'b0);
            repeat (4) send(D21_5, 1'b1, 1'b0);
        end
        chk_sync(1'b1, "err_tolerance");
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        chk_sync(1'b1, "three_bad_still_sync");
        send(10'h000, 1'b1, 1'b0);
        chk_sync(1'b0, "four_bad_loss");

        // recovery: 3 goods from SA2 reach SA1, so 4 more bads are needed for loss
        send_i2(8);
        chk_sync(1'b1, "reacquire_1");
        send(10'h000, 1'b1, 1'b0);
        repeat (3) send(D21_5, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        chk_sync(1'b1, "recovery_to_sa1");
        send(10'h000, 1'b1, 1'b0);
        chk_sync(1'b0, "recovery_then_loss");

        // odd-position comma during acquisition
        send(m_rdp ? K28_5_POS : K28_5_NEG, 1'b1, 1'b0);
        send(m_rdp ? D16_2_RDP : D16_2_RDN, 1'b1, 1'b0);
        send(D21_5, 1'b1, 1'b0);
        send(m_rdp ? K28_5_POS : K28_5_NEG, 1'b1, 1'b0);
        chk_sync(1'b0, "odd_comma");
        repeat (4) send(D21_5, 1'b1, 1'b0);
        chk_sync(1'b0, "odd_comma_stays_loss");

        // signal loss for one cycle, then 6 groups to re-acquire
        i2_phase = 0;
        send_i2(8);
        chk_sync(1'b1, "pre_sigloss");
        if (!i2_phase) send_i2(1);
        send(i2_cg(), 1'b0, 1'b0);
        chk_sync(1'b0, "sigloss");
        send_i2(5);
        chk_sync(1'b0, "sigloss_5_groups");
        send_i2(1);
        chk_sync(1'b1, "sigloss_6_groups");

        // reset in SYNC_ACQUIRED_3
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b1, 1'b0);
        send(10'h000, 1'b0, 1'b1);
        chk_sync(1'b0, "mid_reset");
        i2_phase = 0;
        send_i2(6);
        chk_sync(1'b1, "post_reset_acq");

        // randomized /I2/ stream with injected faults
        for (int c = 0; c < 3000; c++) begin
            r   = int'($urandom_range(0, 999));
            rst = (r < 4);
            sd  = !(r >= 4 && r < 12);
            r   = int'($urandom_range(0, 999));
            if (r < 800)      g = i2_cg();
            else if (r < 880) g = 10'h000;
            else if (r < 930) g = D21_5;
            else if (r < 950) g = m_rdp ? K28_5_NEG : K28_5_POS;
            else              g = 10'($urandom);
            send(g, sd, rst);
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #4;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_sync.md
# pcs_sync

- Clause-36 PCS synchronization controller for the 1000BASE-X receive path.
- Takes raw 10-bit code-groups from the PMA and establishes and tracks comma alignment and even/odd code-group parity.
- Labels each code-group and forwards it as `sudi` to `receive`.
- Drives `sync_status`, which gates the `receive` state machine: `receive` only decodes frames while `sync_status` is high.

## Interface
- `GOOD_CGS_MAX`, default 3: consecutive good code-groups needed to step back one SYNC_ACQUIRED level.
- `rx_clk`  in  1  receive code-group clock; one code-group per rising edge.
- `mr_main_reset`  in  1  reset, synchronous, active-high.
- `code_group`  in  10  aligned PMA code-group; bit 9 = `a` (first transmitted), bit 0 = `j`.
- `signal_detect`  in  1  PMD signal present.
- `sudi`  out  11  `{rx_even, code_group}` labelled code-group to `receive`.
- `sync_status`  out  1  1 = OK, 0 = FAIL.
- One clock; reset is synchronous and active-high.

## Operation
- **Comma:** `code_group[9:3]` is 7'b0011111 or 7'b1100000.
- **ones:** popcount of the 10 bits.
- **INVALID** when any of these holds:
  - ones ∉ {4,5,6};
  - popcount of `[9:4]` ∉ {2,3,4};
  - popcount of `[3:0]` ∉ {1,2,3};
  - ones==6 while RD=+;
  - ones==4 while RD=−.
- **Running disparity (RD):**
  - On a valid group: ones 6 sets RD+, ones 4 sets RD−, ones 5 leaves it unchanged.
  - On an invalid group: RD is unchanged.
  - In LOSS_OF_SYNC, RD follows ones 6/4 unconditionally, with no check.
- **Group classes:**
  - cgbad = INVALID, or comma while registered `rx_even`==1 (odd-position comma).
  - cggood = !cgbad.
  - /D/ = valid non-comma.
- **Global rule:** `signal_detect`==0 forces LOSS_OF_SYNC from any state.
- **States** (transitions are evaluated on the incoming group against the registered `rx_even`):
  - LOSS_OF_SYNC: `sync_status`=0; `rx_even` toggles. Comma → COMMA_DETECT_1; otherwise stay.
  - COMMA_DETECT_n (n=1..3): `rx_even`=1. /D/ → ACQUIRE_SYNC_n (n=1,2) or SYNC_ACQUIRED_1 (n=3); anything else → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_n (n=1,2): `rx_even` toggles.
    - cgbad → LOSS_OF_SYNC.
    - Comma with registered `rx_even`==0 → COMMA_DETECT_{n+1}.
    - Otherwise stay.
  - SYNC_ACQUIRED_1: `sync_status`=1; `rx_even` toggles. cgbad → SYNC_ACQUIRED_2; otherwise stay.
  - SYNC_ACQUIRED_k (k=2..4): `rx_even` toggles; `good_cgs`=0.
    - cggood → SYNC_ACQUIRED_kA.
    - cgbad → SYNC_ACQUIRED_{k+1}; from k=4 → LOSS_OF_SYNC.
  - SYNC_ACQUIRED_kA: `rx_even` toggles; `good_cgs`++.
    - cgbad → SYNC_ACQUIRED_{k+1}; from 4A → LOSS_OF_SYNC.
    - cggood with `good_cgs`==GOOD_CGS_MAX → SYNC_ACQUIRED_{k−1}; from 2A → SYNC_ACQUIRED_1.
    - Otherwise stay.
  - `sync_status` is 1 in every SYNC_ACQUIRED* state and 0 elsewhere.
- **Width:** `good_cgs` is 2 bits and saturates. It never wraps, because a transition occurs at GOOD_CGS_MAX.

## Timing
- All outputs are registered.
- `sudi` carries the group from edge N at edge N+1, labelled with the `rx_even` of the state entered at edge N+1. Latency is 1 cycle.
- `sync_status` updates on the same edge as the state change.
- **Reset values** (every output and register):
  - state = LOSS_OF_SYNC;
  - `rx_even`=0;
  - RD=−;
  - `good_cgs`=0;
  - `sudi`=11'h000;
  - `sync_status`=0.
- Reset mid-stream takes effect on the next edge regardless of state.
- Reset has priority over `signal_detect`.
- **Simultaneous events:**
  - `signal_detect` loss wins over any cggood transition.
  - Comma plus INVALID counts as cgbad.

## Structure
- **Package `pcs_sync_pkg`:**
  - state enum (13 states);
  - comma patterns K28.5−=10'b0011111010, K28.5+=10'b1100000101;
  - D16.2 code-groups.
- **Sub-module `cg_check`** (combinational):
  - inputs: `code_group`, RD;
  - outputs: comma, invalid, rd_next.
- The FSM, counters and output registers live in `pcs_sync`.

## Test plan
All stimulus below uses the /I2/ stream: 0011111010 (K28.5), then 1001000101 (D16.2).

- **Acquisition:** apply reset, hold `signal_detect`=1, send /I2/ pairs from cycle 0.
  - `sync_status` rises after the 6th group's edge.
  - `sudi[10]` then alternates 1,0 with 1 on every K28.5.
- **Odd comma:** in ACQUIRE_SYNC_1, send K28.5 one group early (odd position) → LOSS_OF_SYNC; `sync_status` stays 0.
- **Error tolerance:** after sync, inject 3 groups of 10'h000, each separated by 4 /D/ → `sync_status` stays 1.
  - Then 4 consecutive 10'h000 → `sync_status`=0 on the 4th edge.
- **Recovery:** from SYNC_ACQUIRED_2, send 3 good groups → back in SYNC_ACQUIRED_1; a following single bad group → SYNC_ACQUIRED_2, not LOSS_OF_SYNC.
- **Signal loss:** drop `signal_detect` for one cycle while synced → `sync_status`=0 next edge; re-acquisition needs 6 groups.
- **Reset mid-operation:** assert `mr_main_reset` in SYNC_ACQUIRED_3 → next edge `sudi`=0, `sync_status`=0, RD=−.
